// File: rtl/rx_stream_arbiter.sv
// rx_stream_arbiter: packet-granular round-robin arbiter sharing the dataplane RX stream.
// A grant is held from the first beat until the tlast handshake, so packets never interleave.
module rx_stream_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_PORTS  = 4,
    localparam int GW = $clog2(NUM_PORTS),
    localparam int KW = DATA_WIDTH / 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_PORTS-1:0]       s_tvalid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_PORTS*KW-1:0]    s_tkeep,
    input  logic [NUM_PORTS-1:0]       s_tlast,
    output logic [NUM_PORTS-1:0]       s_tready,
    output logic                       m_tvalid,
    output logic [DATA_WIDTH-1:0]      m_tdata,
    output logic [KW-1:0]              m_tkeep,
    output logic                       m_tlast,
    input  logic                       m_tready,
    input  logic [NUM_PORTS-1:0]       port_enable,
    output logic [GW-1:0]              grant_id,
    output logic                       busy,
    output logic [NUM_PORTS*16-1:0]    pkt_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } state_t;

    state_t          state_r;
    logic [GW-1:0]   rr_ptr_r;
    logic [GW-1:0]   grant_id_r;
    logic            busy_r;
    logic [GW:0]     pick_s;
    logic [GW-1:0]   next_ptr_s;
    logic            eop_s;

    // First requesting port at or after ptr, wrapping; MSB flags that any port requested.
    function automatic logic [GW:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                            input logic [GW-1:0]        ptr);
        logic [GW:0] result;
        int          idx;
        result = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_PORTS;
            if (req[idx]) begin
                result = {1'b1, GW'(idx)};
            end
        end
        return result;
    endfunction

    // Arbitration request and pointer successor of the current grant
    always_comb begin
        pick_s = rr_pick(s_tvalid & port_enable, rr_ptr_r);
        if (int'(grant_id_r) == NUM_PORTS - 1) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_id_r + GW'(1);
        end
    end

    // Unregistered data path: the granted slice passes straight through while in PASS
    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tkeep  = '0;
        m_tlast  = 1'b0;
        s_tready = '0;
        if (state_r == ST_PASS) begin
            m_tvalid             = s_tvalid[grant_id_r];
            m_tdata              = s_tdata[int'(grant_id_r)*DATA_WIDTH +: DATA_WIDTH];
            m_tkeep              = s_tkeep[int'(grant_id_r)*KW +: KW];
            m_tlast              = s_tlast[grant_id_r];
            s_tready[grant_id_r] = m_tready;
        end else begin
            s_tready = '0;
        end
    end

    assign eop_s = (state_r == ST_PASS) && m_tvalid && m_tready && m_tlast;

    // Arbiter FSM: grant in IDLE, hold through PASS until the tlast handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= '0;
            grant_id_r <= '0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_s[GW]) begin
                        grant_id_r <= pick_s[GW-1:0];
                        state_r    <= ST_PASS;
                        busy_r     <= 1'b1;
                    end
                end
                ST_PASS: begin
                    if (eop_s) begin
                        rr_ptr_r <= next_ptr_s;
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_id = grant_id_r;
    assign busy     = busy_r;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
        logic [15:0] cnt_r;

        // Completed-packet counter for this port, sticking at all-ones
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_r <= 16'h0000;
            end else if (eop_s && (int'(grant_id_r) == p) && (cnt_r != 16'hFFFF)) begin
                cnt_r <= cnt_r + 16'h0001;
            end
        end

        assign pkt_cnt[p*16 +: 16] = cnt_r;
    end

endmodule

// File: tb/tb_rx_stream_arbiter.sv
// Scoreboard bench for rx_stream_arbiter: directed packets per port, expected beat order
// pushed by hand, and a negedge monitor that compares every accepted output beat.
`timescale 1ns/1ps
module tb_rx_stream_arbiter;

    localparam int DW = 64;
    localparam int NP = 4;
    localparam int GW = 2;
    localparam int KW = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NP-1:0]    s_tvalid;
    logic [NP*DW-1:0] s_tdata;
    logic [NP*KW-1:0] s_tkeep;
    logic [NP-1:0]    s_tlast;
    logic [NP-1:0]    s_tready;
    logic             m_tvalid;
    logic [DW-1:0]    m_tdata;
    logic [KW-1:0]    m_tkeep;
    logic             m_tlast;
    logic             m_tready;
    logic [NP-1:0]    port_enable;
    logic [GW-1:0]    grant_id;
    logic             busy;
    logic [NP*16-1:0] pkt_cnt;

    typedef struct packed {
        logic [GW-1:0] port;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    beat_t src_q [NP][$];
    beat_t sb_q [$];
    int    checks = 0;
    int    failures = 0;
    bit    rdy_toggle = 1'b0;

    always #5 clk = ~clk;

    rx_stream_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tready(m_tready),
        .port_enable(port_enable), .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk_beat(input int p, input int b, input int n,
                                      input logic [DW-1:0] base, input logic [DW-1:0] step,
                                      input logic [KW-1:0] keep_last);
        beat_t bt;
        bt.port = GW'(p);
        bt.data = base + step * DW'(b);
        bt.last = (b == n - 1);
        bt.keep = (b == n - 1) ? keep_last : 8'hFF;
        return bt;
    endfunction

    task automatic add_src(input int p, input int n, input logic [DW-1:0] base,
                           input logic [DW-1:0] step, input logic [KW-1:0] keep_last);
        for (int b = 0; b < n; b++) src_q[p].push_back(mk_beat(p, b, n, base, step, keep_last));
    endtask

    task automatic add_exp(input int p, input int n, input logic [DW-1:0] base,
                           input logic [DW-1:0] step, input logic [KW-1:0] keep_last);
        for (int b = 0; b < n; b++) sb_q.push_back(mk_beat(p, b, n, base, step, keep_last));
    endtask

    task automatic check_cnt(input int p, input logic [15:0] exp);
        check($sformatf("pkt_cnt%0d", p), {48'h0, pkt_cnt[p*16 +: 16]}, {48'h0, exp});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((sb_q.size() != 0) && (n < budget)) begin
            @(negedge clk); #1;
            n++;
        end
        check({name, "_drain"}, 64'(sb_q.size()), 64'd0);
        @(negedge clk); #1;
        check({name, "_busy_off"}, {63'h0, busy}, 64'd0);
    endtask

    // Source driver: pops beats accepted at the previous posedge and presents queue heads
    initial begin : driver
        logic [NP-1:0] fire;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        forever begin
            @(negedge clk);
            fire = s_tvalid & s_tready;
            @(posedge clk);
            if (!rst_n) fire = '0;
            #1;
            for (int p = 0; p < NP; p++) begin
                if (fire[p] && (src_q[p].size() > 0)) src_q[p].delete(0);
                if (src_q[p].size() > 0) begin
                    s_tvalid[p]           = 1'b1;
                    s_tdata[p*DW +: DW]   = src_q[p][0].data;
                    s_tkeep[p*KW +: KW]   = src_q[p][0].keep;
                    s_tlast[p]            = src_q[p][0].last;
                end else begin
                    s_tvalid[p]           = 1'b0;
                    s_tdata[p*DW +: DW]   = '0;
                    s_tkeep[p*KW +: KW]   = '0;
                    s_tlast[p]            = 1'b0;
                end
            end
            m_tready = rdy_toggle ? ~m_tready : 1'b1;
        end
    end

    // Monitor: ready routing every cycle, and each accepted beat against the scoreboard
    initial begin : monitor
        beat_t         exp_b;
        logic [NP-1:0] exp_rdy;
        forever begin
            @(negedge clk);
            exp_rdy = busy ? (NP'(m_tready) << grant_id) : '0;
            check("s_tready", {60'h0, s_tready}, {60'h0, exp_rdy});
            if (m_tvalid && m_tready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got data %0h from port %0d expected no beat",
                             m_tdata, grant_id);
                end else begin
                    exp_b = sb_q.pop_front();
                    check("beat_port", {62'h0, grant_id}, {62'h0, exp_b.port});
                    check("beat_data", m_tdata, exp_b.data);
                    check("beat_keep", {56'h0, m_tkeep}, {56'h0, exp_b.keep});
                    check("beat_last", {63'h0, m_tlast}, {63'h0, exp_b.last});
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int span;
        int n;
        bit started;
        port_enable = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        check("rst_m_tvalid", {63'h0, m_tvalid}, 64'd0);
        check("rst_s_tready", {60'h0, s_tready}, 64'd0);
        check("rst_busy", {63'h0, busy}, 64'd0);
        check("rst_grant", {62'h0, grant_id}, 64'd0);
        check("rst_pkt_cnt", pkt_cnt, 64'd0);
        check("rst_m_data", m_tdata, 64'd0);
        check("rst_m_keep_last", {55'h0, m_tkeep, m_tlast}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        // Round robin: four ports, two 2-beat packets each, expected 0,1,2,3,0,1,2,3
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < 2; k++) add_src(p, 2, DW'((p << 8) | (k << 4)), 64'd1, 8'h0F);
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < NP; p++) add_exp(p, 2, DW'((p << 8) | (k << 4)), 64'd1, 8'h0F);
        span = 0;
        n = 0;
        started = 1'b0;
        while ((sb_q.size() != 0) && (n < 200)) begin
            @(negedge clk); #1;
            n++;
            if (m_tvalid) started = 1'b1;
            if (started) span++;
        end
        check("rr_span", 64'(span), 64'd23);
        wait_drain("rr", 10);
        for (int p = 0; p < NP; p++) check_cnt(p, 16'd2);

        // Single port 2, four beats 0x11..0x44, arbitration latency of one cycle
        add_src(2, 4, 64'h11, 64'h11, 8'hFF);
        add_exp(2, 4, 64'h11, 64'h11, 8'hFF);
        @(negedge clk); #1;
        check("lat_s_tvalid", {63'h0, s_tvalid[2]}, 64'd1);
        check("lat_m_tvalid_idle", {63'h0, m_tvalid}, 64'd0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk); #1;
            check($sformatf("single_valid_beat%0d", b), {63'h0, m_tvalid}, 64'd1);
        end
        @(negedge clk); #1;
        check("single_busy_drop", {63'h0, busy}, 64'd0);
        check("single_valid_drop", {63'h0, m_tvalid}, 64'd0);
        check("single_sb_empty", 64'(sb_q.size()), 64'd0);
        check_cnt(2, 16'd3);

        // Backpressure: port 0 (rr_ptr=3 wraps to 0) must finish before port 1 appears
        rdy_toggle = 1'b1;
        add_src(0, 4, 64'hA0, 64'd1, 8'hFF);
        add_src(1, 2, 64'hB0, 64'd1, 8'h3F);
        add_exp(0, 4, 64'hA0, 64'd1, 8'hFF);
        add_exp(1, 2, 64'hB0, 64'd1, 8'h3F);
        wait_drain("bp", 80);
        rdy_toggle = 1'b0;
        check_cnt(0, 16'd3);
        check_cnt(1, 16'd3);

        // Enable mask 0101 from rr_ptr=2: order 2,0,2,0; port 2 disabled mid third packet
        port_enable = 4'b0101;
        add_src(0, 2, 64'hC0, 64'd1, 8'hFF);
        add_src(0, 2, 64'hC4, 64'd1, 8'hFF);
        add_src(2, 2, 64'hD0, 64'd1, 8'hFF);
        add_src(2, 2, 64'hD4, 64'd1, 8'hFF);
        add_src(2, 2, 64'hD8, 64'd1, 8'hFF);
        add_src(1, 2, 64'hE0, 64'd1, 8'hFF);
        add_src(3, 2, 64'hF0, 64'd1, 8'hFF);
        add_exp(2, 2, 64'hD0, 64'd1, 8'hFF);
        add_exp(0, 2, 64'hC0, 64'd1, 8'hFF);
        add_exp(2, 2, 64'hD4, 64'd1, 8'hFF);
        add_exp(0, 2, 64'hC4, 64'd1, 8'hFF);
        n = 0;
        while ((sb_q.size() > 3) && (n < 100)) begin
            @(negedge clk); #1;
            n++;
        end
        check("mask_mid_pkt", 64'(sb_q.size()), 64'd3);
        port_enable = 4'b0001;
        wait_drain("mask", 40);
        repeat (3) @(negedge clk);
        #1;
        check("mask_idle_valid", {63'h0, m_tvalid}, 64'd0);
        check("mask_p2_left", 64'(src_q[2].size()), 64'd2);
        check("mask_p1_left", 64'(src_q[1].size()), 64'd2);
        check("mask_p3_left", 64'(src_q[3].size()), 64'd2);
        check_cnt(0, 16'd5);
        check_cnt(2, 16'd5);
        for (int p = 0; p < NP; p++) src_q[p].delete();
        repeat (2) @(negedge clk);
        #1;
        port_enable = 4'hF;

        // Reset on beat 2 of a 5-beat packet from port 2 (rr_ptr=1)
        add_src(2, 5, 64'h50, 64'd1, 8'hFF);
        add_exp(2, 5, 64'h50, 64'd1, 8'hFF);
        n = 0;
        while ((sb_q.size() > 3) && (n < 50)) begin
            @(negedge clk); #1;
            n++;
        end
        check("rst_mid_beat2", {63'h0, m_tvalid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_m_tvalid", {63'h0, m_tvalid}, 64'd0);
        check("arst_s_tready", {60'h0, s_tready}, 64'd0);
        check("arst_busy", {63'h0, busy}, 64'd0);
        check("arst_pkt_cnt", pkt_cnt, 64'd0);
        check("arst_grant", {62'h0, grant_id}, 64'd0);
        sb_q.delete();
        @(posedge clk); #2;
        for (int p = 0; p < NP; p++) src_q[p].delete();
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        add_src(0, 1, 64'h60, 64'd1, 8'hFF);
        add_src(1, 1, 64'h70, 64'd1, 8'hFF);
        add_exp(0, 1, 64'h60, 64'd1, 8'hFF);
        add_exp(1, 1, 64'h70, 64'd1, 8'hFF);
        wait_drain("post_rst", 30);
        check_cnt(0, 16'd1);
        check_cnt(1, 16'd1);
        check_cnt(2, 16'd0);

        // Saturation: port 1 counter preset to FFFE, three more packets
        force dut.g_cnt[1].cnt_r = 16'hFFFE;
        @(negedge clk); #1;
        release dut.g_cnt[1].cnt_r;
        @(negedge clk); #1;
        check_cnt(1, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            add_src(1, 1, 64'h80 + 64'(k), 64'd1, 8'hFF);
            add_exp(1, 1, 64'h80 + 64'(k), 64'd1, 8'hFF);
        end
        wait_drain("sat", 40);
        check_cnt(1, 16'hFFFF);
        check_cnt(0, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_stream_arbiter.md
# rx_stream_arbiter

Packet-granular round-robin arbiter that shares the single AXI-Stream RX ingress of `dataplane_top` between up to NUM_PORTS upstream stream sources. A grant is held from the first beat of a packet until the `tlast` beat is accepted, so packets never interleave. Per-port enables come from the AXI4-Lite CSR block. Per-port accepted-packet counters are exposed for CSR readback.

## Interface
- DATA_WIDTH, 64, stream data width in bits; multiple of 8.
- NUM_PORTS, 4, number of requesting streams; 2..8.
- GW, $clog2(NUM_PORTS), grant index width (localparam).
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- s_tvalid  in  NUM_PORTS  per-port valid.
- s_tdata  in  NUM_PORTS*DATA_WIDTH  per-port data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_tkeep  in  NUM_PORTS*DATA_WIDTH/8  per-port byte keep, packed the same way.
- s_tlast  in  NUM_PORTS  per-port end of packet.
- s_tready  out  NUM_PORTS  per-port ready.
- m_tvalid  out  1  to dataplane RX `tvalid`.
- m_tdata  out  DATA_WIDTH  to RX `tdata`.
- m_tkeep  out  DATA_WIDTH/8  to RX `tkeep`.
- m_tlast  out  1  to RX `tlast`.
- m_tready  in  1  from RX `tready`.
- port_enable  in  NUM_PORTS  CSR mask; 1 = port may win arbitration.
- grant_id  out  GW  currently or last granted port.
- busy  out  1  1 while a packet is in flight (state PASS).
- pkt_cnt  out  NUM_PORTS*16  per-port count of completed packets; saturates at 16'hFFFF.

## Operation
- FSM states: IDLE, PASS. Reset state is IDLE.
- IDLE: request vector req = s_tvalid & port_enable. If req is nonzero, select the first set bit searching from rr_ptr upward with wrap-around (rr_ptr, rr_ptr+1, …, NUM_PORTS-1, 0, …). Register the result into grant_id and go to PASS. If req is zero, stay in IDLE.
- PASS:
  - m_tvalid = s_tvalid[grant_id].
  - m_tdata, m_tkeep and m_tlast are the grant_id slices, combinational mux.
  - s_tready[grant_id] = m_tready. All other s_tready bits are 0.
- End of packet: a beat with m_tvalid & m_tready & m_tlast completes the packet.
  - pkt_cnt[grant_id] increments, saturating at 16'hFFFF.
  - rr_ptr <= (grant_id + 1) mod NUM_PORTS.
  - FSM returns to IDLE.
- IDLE outputs: m_tvalid = 0, m_tdata = 0, m_tkeep = 0, m_tlast = 0, s_tready = 0. grant_id holds its last value.
- port_enable is sampled only in IDLE. Deasserting the granted port's enable mid-packet does not truncate the packet; it affects only the next arbitration.
- A granted source that drops s_tvalid mid-packet keeps the grant. The arbiter waits indefinitely; there is no timeout.
- Single-beat packet (tlast on the first beat): one PASS cycle if m_tready = 1, then IDLE.
- With exactly one requester, that port wins every arbitration regardless of rr_ptr.

## Timing
- Reset values: state IDLE, rr_ptr 0, grant_id 0, busy 0, pkt_cnt all 0, m_tvalid 0, s_tready 0, m_tdata/m_tkeep/m_tlast 0.
- Reset asserted mid-packet: all of the above apply immediately and asynchronously; the partial packet is abandoned.
- Arbitration latency: a request seen in IDLE at edge N is granted at edge N, and the first beat can transfer in cycle N+1.
- Inter-packet gap: exactly one IDLE cycle between the tlast beat and the next packet's first beat.
- Throughput: one beat per cycle within a packet while s_tvalid and m_tready are both high.
- Data path: no registers between s_* and m_*; the only cycle of latency is the arbitration cycle.
- busy = (state == PASS); asserts the cycle after the grant, deasserts the cycle after the tlast handshake.
- pkt_cnt and rr_ptr update at the edge that completes the tlast handshake.

## Test plan
- Single port: port 2 sends a 4-beat packet (tdata 0x11..0x44, tkeep 0xFF), m_tready = 1 -> m_tvalid high 4 consecutive cycles starting 1 cycle after s_tvalid rises. Data matches in order, tlast on beat 4, pkt_cnt[2] = 1, busy drops after the beat.
- Round-robin fairness: all 4 ports continuously send 2-beat packets, all enabled -> grant order 0,1,2,3,0,1… After 8 packets, each pkt_cnt = 2, with one IDLE gap between packets.
- No interleave under backpressure: port 0 mid-packet while port 1 requests; toggle m_tready 1,0,1,0 -> no port-1 beat appears until port-0 tlast is accepted, and s_tready[1] stays 0 throughout.
- Enable mask: port_enable = 4'b0101 with all ports requesting -> only ports 0 and 2 are granted, alternating. Clearing bit 2 mid-packet of port 2 -> that packet still completes fully.
- Reset mid-packet: assert rst_n = 0 on beat 2 of a 5-beat packet -> m_tvalid, s_tready, busy and pkt_cnt go to 0 immediately. After release, port 0 is granted first.
- Counter saturation: force pkt_cnt[1] to 16'hFFFE, then send 3 packets on port 1 -> count reads 16'hFFFF and stays there.
